// File: rtl/riscv_regfile_pkg.sv
// Shared types for the integer register-file writeback path.
// Address/data widths and the per-source writeback request bundle.
package riscv_regfile_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   xlen_t;

  typedef struct packed {
    reg_addr_t rd;
    xlen_t     data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant,
// pointer moves past the winner on every grant.
module rr_arbiter #(
  parameter int N = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  import riscv_regfile_pkg::*;

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] ptr_nxt;
  logic [IW-1:0] idx;
  logic          found;

  function automatic logic [IW-1:0] wrap(
    input logic [IW-1:0] p,
    input int            k
  );
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = wrap(rr_ptr, k);
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = idx;
      end
    end
  end

  always_comb begin
    ptr_nxt = '0;
    if (gnt_idx != IW'(N - 1))
      ptr_nxt = gnt_idx + IW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr_ptr <= '0;
    else if (|gnt)
      rr_ptr <= ptr_nxt;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among writeback sources
// and tracks pending destinations in a busy scoreboard.
module regfile_wb_arbiter #(
  parameter int NUM_WB = 3,
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid,
  input  logic [REG_AW-1:0]        issue_rd,
  output logic                     issue_ready,
  input  logic [REG_AW-1:0]        rs1_addr,
  input  logic [REG_AW-1:0]        rs2_addr,
  output logic                     rs1_busy,
  output logic                     rs2_busy,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*REG_AW-1:0] wb_rd,
  input  logic [NUM_WB*XLEN-1:0]   wb_data,
  output logic [NUM_WB-1:0]        wb_ready,
  input  logic                     flush,
  output logic                     rf_write,
  output logic [REG_AW-1:0]        rf_rd_addr,
  output logic [XLEN-1:0]          rf_rd
);

  import riscv_regfile_pkg::*;

  localparam int NREG = 1 << REG_AW;
  localparam int IW   = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;

  wb_req_t           req [NUM_WB];
  wb_req_t           sel;
  logic [NUM_WB-1:0] gnt;
  logic [IW-1:0]     gnt_idx;
  logic              grant;
  logic              issue_fire;
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;

  always_comb begin
    for (int i = 0; i < NUM_WB; i++) begin
      req[i].rd   = wb_rd[i*REG_AW +: REG_AW];
      req[i].data = wb_data[i*XLEN +: XLEN];
    end
  end

  rr_arbiter #(.N(NUM_WB)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (wb_valid),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign sel   = req[gnt_idx];
  assign grant = rst_n & (|gnt);

  assign wb_ready   = rst_n ? gnt : '0;
  assign rf_write   = grant & (sel.rd != '0);
  assign rf_rd_addr = grant ? sel.rd : '0;
  assign rf_rd      = grant ? sel.data : '0;

  assign rs1_busy    = rst_n & busy[rs1_addr];
  assign rs2_busy    = rst_n & busy[rs2_addr];
  assign issue_ready = rst_n & ~flush & ~busy[issue_rd];
  assign issue_fire  = issue_valid & issue_ready & (issue_rd != '0);

  // Issue stalls on a busy rd, so set and clear never hit one register.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (grant)
        busy_nxt[sel.rd] = 1'b0;
      if (issue_fire)
        busy_nxt[issue_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

endmodule
